// File: rtl/conv_param_mac_if.sv
// conv_param_mac_if: stream bundle for the parametrised convolution MAC.
//   X input stream   : s_valid_x / s_ready_x / s_data_in_x (signed DATA_WIDTH_X)
//   F input stream   : s_valid_f / s_ready_f / s_data_in_f (signed DATA_WIDTH_F)
//   keep_f           : filter retention request, sampled on the last output handshake
//   Y output stream  : m_valid_y / m_ready_y / m_data_out_y (signed OUT_WIDTH), sat_flag
// Modports: slave = the MAC itself, master = the block feeding and draining it.
interface conv_param_mac_if #(
  parameter int DATA_WIDTH_X = 8,
  parameter int DATA_WIDTH_F = 8,
  parameter int OUT_WIDTH    = 21
);
  logic                           s_valid_x;
  logic                           s_ready_x;
  logic signed [DATA_WIDTH_X-1:0] s_data_in_x;
  logic                           s_valid_f;
  logic                           s_ready_f;
  logic signed [DATA_WIDTH_F-1:0] s_data_in_f;
  logic                           keep_f;
  logic                           m_valid_y;
  logic                           m_ready_y;
  logic signed [OUT_WIDTH-1:0]    m_data_out_y;
  logic                           sat_flag;

  modport slave (
    input  s_valid_x, s_data_in_x, s_valid_f, s_data_in_f, keep_f, m_ready_y,
    output s_ready_x, s_ready_f, m_valid_y, m_data_out_y, sat_flag
  );

  modport master (
    output s_valid_x, s_data_in_x, s_valid_f, s_data_in_f, keep_f, m_ready_y,
    input  s_ready_x, s_ready_f, m_valid_y, m_data_out_y, sat_flag
  );
endinterface

// File: rtl/conv_param_mac.sv
// conv_param_mac: buffers one X vector and one F vector, then computes
//   y[n] = sum_{k=0..F_SIZE-1} x[n+k]*f[k],  n = 0..X_SIZE-F_SIZE
// with a read / multiply / accumulate pipeline, one output at a time.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-low
//   io    - conv_param_mac_if.slave: X and F input streams, keep_f,
//           Y output stream with sat_flag
// The filter can be retained across X vectors (keep_f on the final output
// handshake), in which case only X has to be reloaded.
module conv_param_mac #(
  parameter int DATA_WIDTH_X = 8,
  parameter int DATA_WIDTH_F = 8,
  parameter int X_SIZE       = 128,
  parameter int F_SIZE       = 32,
  parameter int ACC_SIZE     = DATA_WIDTH_X + DATA_WIDTH_F + $clog2(F_SIZE),
  parameter int OUT_WIDTH    = ACC_SIZE,
  parameter bit SAT_EN       = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  conv_param_mac_if.slave io
);

  localparam int PW = DATA_WIDTH_X + DATA_WIDTH_F;
  localparam int XA = $clog2(X_SIZE);
  localparam int FA = $clog2(F_SIZE);

  localparam logic [XA-1:0] X_LAST = XA'(X_SIZE - 1);
  localparam logic [XA-1:0] N_LAST = XA'(X_SIZE - F_SIZE);
  localparam logic [FA-1:0] F_LAST = FA'(F_SIZE - 1);

  // Signed OUT_WIDTH limits, expressed at accumulator width for comparison.
  localparam logic signed [ACC_SIZE-1:0] SAT_MAX =
    {{(ACC_SIZE-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_SIZE-1:0] SAT_MIN =
    {{(ACC_SIZE-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ST_LOAD, ST_COMP, ST_DRAIN, ST_OUT} state_t;

  function automatic logic clip_hit(input logic signed [ACC_SIZE-1:0] a);
    return SAT_EN && ((a > SAT_MAX) || (a < SAT_MIN));
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] clip(input logic signed [ACC_SIZE-1:0] a);
    logic signed [OUT_WIDTH-1:0] r;
    r = a[OUT_WIDTH-1:0];
    if (SAT_EN && (a > SAT_MAX)) r = SAT_MAX[OUT_WIDTH-1:0];
    else if (SAT_EN && (a < SAT_MIN)) r = SAT_MIN[OUT_WIDTH-1:0];
    return r;
  endfunction

  logic signed [DATA_WIDTH_X-1:0] x_mem [X_SIZE];
  logic signed [DATA_WIDTH_F-1:0] f_mem [F_SIZE];

  state_t                      state;
  logic [XA-1:0]               x_ptr;
  logic [FA-1:0]               f_ptr;
  logic                        x_rdy;
  logic                        f_rdy;
  logic [XA-1:0]               n_idx;
  logic [FA-1:0]               k_idx;
  logic                        vld_p0;
  logic                        first_p0;
  logic                        last_p0;
  logic                        vld_p1;
  logic                        first_p1;
  logic                        last_p1;
  logic                        out_vld;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_sat;

  logic signed [DATA_WIDTH_X-1:0] x_rd_p0;
  logic signed [DATA_WIDTH_F-1:0] f_rd_p0;
  logic signed [PW-1:0]           prod_p1;
  logic signed [ACC_SIZE-1:0]     acc_p2;
  logic signed [ACC_SIZE-1:0]     prod_ext;
  logic signed [ACC_SIZE-1:0]     acc_next;

  logic          x_wr;
  logic          f_wr;
  logic [XA-1:0] x_addr;

  assign x_wr   = io.s_valid_x && x_rdy;
  assign f_wr   = io.s_valid_f && f_rdy;
  assign x_addr = n_idx + XA'(k_idx);

  // The first product of each output loads the accumulator directly.
  always_comb begin
    prod_ext = ACC_SIZE'(prod_p1);
    acc_next = first_p1 ? prod_ext : (acc_p2 + prod_ext);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_LOAD;
      x_ptr    <= '0;
      f_ptr    <= '0;
      x_rdy    <= 1'b1;
      f_rdy    <= 1'b1;
      n_idx    <= '0;
      k_idx    <= '0;
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      last_p0  <= 1'b0;
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      last_p0  <= 1'b0;
      vld_p1   <= vld_p0;
      first_p1 <= first_p0;
      last_p1  <= last_p0;
      case (state)
        ST_LOAD: begin
          // Ready drops on the edge that writes the last slot; the pointer
          // parks there until the vector is released.
          if (x_wr) begin
            if (x_ptr == X_LAST) x_rdy <= 1'b0;
            else                 x_ptr <= x_ptr + 1'b1;
          end
          if (f_wr) begin
            if (f_ptr == F_LAST) f_rdy <= 1'b0;
            else                 f_ptr <= f_ptr + 1'b1;
          end
          if (!x_rdy && !f_rdy) begin
            state <= ST_COMP;
            k_idx <= '0;
          end
        end
        ST_COMP: begin
          vld_p0   <= 1'b1;
          first_p0 <= (k_idx == '0);
          last_p0  <= (k_idx == F_LAST);
          if (k_idx == F_LAST) state <= ST_DRAIN;
          else                 k_idx <= k_idx + 1'b1;
        end
        ST_DRAIN: begin
          if (vld_p1 && last_p1) begin
            out_vld  <= 1'b1;
            out_data <= clip(acc_next);
            out_sat  <= clip_hit(acc_next);
            state    <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (io.m_ready_y) begin
            out_vld <= 1'b0;
            out_sat <= 1'b0;
            if (n_idx == N_LAST) begin
              state <= ST_LOAD;
              n_idx <= '0;
              x_ptr <= '0;
              x_rdy <= 1'b1;
              if (!io.keep_f) begin
                f_ptr <= '0;
                f_rdy <= 1'b1;
              end
            end else begin
              n_idx <= n_idx + 1'b1;
              k_idx <= '0;
              state <= ST_COMP;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Memories and pipeline datapath carry no reset; validity is tracked above.
  always_ff @(posedge clk) begin
    if (x_wr) x_mem[x_ptr] <= io.s_data_in_x;
    if (f_wr) f_mem[f_ptr] <= io.s_data_in_f;
    // p0: synchronous read of x[n+k], f[k]
    x_rd_p0 <= x_mem[x_addr];
    f_rd_p0 <= f_mem[k_idx];
    // p1: registered product
    prod_p1 <= x_rd_p0 * f_rd_p0;
    // p2: accumulate
    if (vld_p1) acc_p2 <= acc_next;
  end

  assign io.s_ready_x    = x_rdy;
  assign io.s_ready_f    = f_rdy;
  assign io.m_valid_y    = out_vld;
  assign io.m_data_out_y = out_data;
  assign io.sat_flag     = out_sat;

endmodule

// File: doc/conv_param_mac.md
Name: conv_param_mac

Overview:
- Parametrised successor to the fixed 128/32 convolution engine.
- Buffers one X vector and one F vector through valid/ready slave streams.
- Computes y[n] = sum_{k=0..F_SIZE-1} x[n+k]*f[k] for n = 0..X_SIZE-F_SIZE, using a pipelined MAC, and streams results out on a valid/ready master.
- Adds a registered multiplier stage, optional output saturation, and filter retention: F is kept across X vectors, so only X is reloaded.

Parameters:
- DATA_WIDTH_X, 8, signed X sample width.
- DATA_WIDTH_F, 8, signed F coefficient width.
- X_SIZE, 128, X vector length; must be >= F_SIZE.
- F_SIZE, 32, filter length; must be >= 2.
- ACC_SIZE, DATA_WIDTH_X+DATA_WIDTH_F+$clog2(F_SIZE), internal accumulator width.
- OUT_WIDTH, ACC_SIZE, m_data_out_y width; must be <= ACC_SIZE.
- SAT_EN, 0. When 1, the accumulator is saturated to signed OUT_WIDTH. When 0, the accumulator is truncated to its low OUT_WIDTH bits.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-low reset. Asserted when 0.
- s_valid_x, in, 1, X sample valid.
- s_ready_x, out, 1, X memory accepting.
- s_data_in_x, in, DATA_WIDTH_X, signed X sample.
- s_valid_f, in, 1, F coefficient valid.
- s_ready_f, out, 1, F memory accepting.
- s_data_in_f, in, DATA_WIDTH_F, signed coefficient.
- keep_f, in, 1, sampled on the final output handshake. When 1, F is retained for the next vector.
- m_valid_y, out, 1, output valid.
- m_ready_y, in, 1, output accepted.
- m_data_out_y, out, OUT_WIDTH, signed result.
- sat_flag, out, 1, high with m_valid_y when the current result was clipped. Always 0 when SAT_EN=0.

Behaviour:
- Reset (reset=0, asynchronous): all state cleared; FSM goes to LOAD.
  - s_ready_x=1, s_ready_f=1.
  - m_valid_y=0, m_data_out_y=0, sat_flag=0.
  - Write pointers = 0.
  - Memory contents are don't-care.
- Reset mid-operation aborts the current vector and discards any partial output.
- LOAD:
  - A sample is written on s_valid & s_ready. Sample i goes to address i.
  - Each s_ready drops on the edge after its SIZE-th write (memory full). X and F fill independently, in either order or interleaved.
  - T is the edge on which the later of the two memories becomes full. COMPUTE begins at T+1.
- COMPUTE, for each n:
  - Stage 1: synchronous read of x[n+k] and f[k], k = 0..F_SIZE-1.
  - Stage 2: registered product.
  - Stage 3: accumulate. The first product loads the accumulator (no separate clear cycle).
  - Products are sign-extended to ACC_SIZE; with the default ACC_SIZE no overflow is possible.
- Output timing:
  - m_valid_y for y[0] rises on edge T+F_SIZE+3.
  - After each handshake, the next y[n] becomes valid exactly F_SIZE+2 cycles later.
  - The pipeline does not overlap across outputs.
- OUTPUT:
  - m_valid_y holds, and m_data_out_y/sat_flag stay stable, until m_ready_y=1.
  - A handshake in the same cycle valid rises is legal.
- Saturation (SAT_EN=1): if the accumulator exceeds the signed OUT_WIDTH range, output is clamped to the max or min value and sat_flag=1.
- Final handshake (n = X_SIZE-F_SIZE):
  - On the next edge, m_valid_y=0, the X pointer resets, and s_ready_x=1.
  - If keep_f=1 at that handshake: F contents and the full flag are kept, s_ready_f stays 0, and COMPUTE starts when X is full again. T is then the X-full edge.
  - If keep_f=0: F is reloaded and s_ready_f=1.
- s_ready_x and s_ready_f are 0 throughout COMPUTE/OUTPUT. Inputs offered then are ignored and not acknowledged.
- Edge case X_SIZE=F_SIZE: exactly one output per vector.

Test Plan:
1. X_SIZE=8, F_SIZE=3. X=1..8, F={1,2,3}, m_ready_y=1, loads interleaved.
   - Expect y = 14, 20, 26, 32, 38, 44.
   - y[0] valid at T+6; each subsequent output 5 cycles after the previous handshake.
2. Same as (1), with m_ready_y stalled 4 cycles on y[2].
   - m_valid_y and data hold at 26; no output is lost or duplicated.
3. Sign extremes: all X=-128, all F=-128, F_SIZE=3.
   - Every y = 49152; correct at the default ACC_SIZE.
4. SAT_EN=1, OUT_WIDTH=12, stimulus as in (3).
   - Every y = 2047 with sat_flag=1.
   - With X=-128 and F=127, every y = -2048 with sat_flag=1.
5. keep_f=1 on the final handshake of (1), then load X=all 1s.
   - s_ready_f stays 0; outputs are all 6; F is not reloaded.
   - A following pass with keep_f=0 raises s_ready_f.
6. reset=0 asserted asynchronously mid-COMPUTE of y[3].
   - m_valid_y=0 immediately and both readies=1.
   - A full reload reproduces the expected results of (1).
